// File: rtl/sync_debounce_edge.sv
// sync_debounce_edge: synchronize and debounce one raw input into a clean level plus one-cycle rise/fall pulses
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   din   raw asynchronous input
//   level debounced level (registered)
//   rise  one-cycle pulse on debounced 0->1 (registered)
//   fall  one-cycle pulse on debounced 1->0 (registered)
module sync_debounce_edge #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    typedef enum logic [1:0] {ST_LOW, ST_WAIT_H, ST_HIGH, ST_WAIT_L} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    logic [SYNC_STAGES-1:0] sync_q;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d, rise_q, rise_d, fall_q, fall_d;
    logic                   syn;
    assign syn   = sync_q[SYNC_STAGES-1];
    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            state_q <= ST_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], din};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end
    // cnt counts consecutive cycles syn has disagreed with the accepted level
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ST_LOW: begin
                state_d = syn ? ST_WAIT_H : ST_LOW;
                cnt_d   = syn ? ONE : '0;
            end
            ST_WAIT_H: begin
                if (!syn) begin
                    state_d = ST_LOW;
                end else if (cnt_q == LAST) begin
                    state_d = ST_HIGH;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            ST_HIGH: begin
                state_d = syn ? ST_HIGH : ST_WAIT_L;
                cnt_d   = syn ? '0 : ONE;
            end
            ST_WAIT_L: begin
                if (syn) begin
                    state_d = ST_HIGH;
                end else if (cnt_q == LAST) begin
                    state_d = ST_LOW;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = ST_LOW;
                level_d = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_sync_debounce_edge.sv
// tb_sync_debounce_edge: scoreboard bench comparing sync_debounce_edge against a run-length reference model
module tb_sync_debounce_edge;
    localparam int SS = 2;
    localparam int DB = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;
    logic level, rise, fall;
    int checks = 0;
    int failures = 0;
    int rise_n = 0;
    int fall_n = 0;
    logic [2:0] sb[$];
    // reference: din delayed SS edges; level flips after DB consecutive disagreeing samples
    bit sh[SS];
    int run = 0;
    bit lvl = 1'b0;

    sync_debounce_edge #(.SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .din(din), .level(level), .rise(rise), .fall(fall)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            logic [2:0] e;
            e = sb.pop_front();
            checks++;
            if ({level, rise, fall} !== e) begin
                failures++;
                $display("FAIL out t=%0t got level/rise/fall=%b exp=%b", $time, {level, rise, fall}, e);
            end
            if (rise === 1'b1) rise_n++;
            if (fall === 1'b1) fall_n++;
        end
    end

    task automatic cyc(input bit r, input bit d);
        bit s, rp, fp;
        @(negedge clk);
        rst = r;
        din = d;
        @(posedge clk);
        #1;
        rp = 1'b0;
        fp = 1'b0;
        if (r) begin
            for (int i = 0; i < SS; i++) sh[i] = 1'b0;
            run = 0;
            lvl = 1'b0;
        end else begin
            s = sh[SS-1];
            for (int i = SS - 1; i > 0; i--) sh[i] = sh[i-1];
            sh[0] = d;
            run = (s != lvl) ? run + 1 : 0;
            if (run == DB) begin
                lvl = ~lvl;
                rp = lvl;
                fp = ~lvl;
                run = 0;
            end
        end
        sb.push_back({lvl, rp, fp});
    endtask

    task automatic chk(input string n, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", n, got, exp);
        end
    endtask

    task automatic hold(input bit d, input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, d);
    endtask

    initial begin
        int r0, f0, len;
        bit d;
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        hold(1'b0, 6);
        // clean rise
        r0 = rise_n; f0 = fall_n;
        hold(1'b1, 10);
        chk("rise_count_clean", rise_n - r0, 1);
        chk("fall_count_clean_rise", fall_n - f0, 0);
        chk("level_after_rise", int'(level), 1);
        // clean fall
        r0 = rise_n; f0 = fall_n;
        hold(1'b0, 10);
        chk("fall_count_clean", fall_n - f0, 1);
        chk("level_after_fall", int'(level), 0);
        // bounce reject: 1,1,0,1,1,1 then low
        r0 = rise_n; f0 = fall_n;
        hold(1'b1, 2); hold(1'b0, 1); hold(1'b1, 3); hold(1'b0, 8);
        chk("rise_count_bounce", rise_n - r0, 0);
        chk("fall_count_bounce", fall_n - f0, 0);
        chk("level_after_bounce", int'(level), 0);
        // bounce then settle high
        r0 = rise_n;
        hold(1'b1, 1); hold(1'b0, 1); hold(1'b1, 1); hold(1'b0, 1); hold(1'b1, 10);
        chk("rise_count_settle", rise_n - r0, 1);
        hold(1'b0, 10);
        // reset mid debounce (WAIT_H, cnt=2), then recover with din still 1
        r0 = rise_n;
        hold(1'b1, 4);
        cyc(1'b1, 1'b1);
        chk("level_during_rst", int'(level), 0);
        chk("rise_count_rst", rise_n - r0, 0);
        hold(1'b1, 4);
        chk("rise_before_latency", rise_n - r0, 0);
        hold(1'b1, 5);
        chk("rise_after_rst", rise_n - r0, 1);
        // randomized runs with occasional reset
        for (int k = 0; k < 120; k++) begin
            d = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 7);
            if ($urandom_range(0, 39) == 0) cyc(1'b1, d);
            hold(d, len);
        end
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
